// File: rtl/mtimer.sv
`default_nettype none
// ============================================================================
// Module   : mtimer
// Purpose  : RISC-V machine timer. Holds a 64-bit mtime counter advanced by a
//            programmable prescaler and a 64-bit mtimecmp compare register,
//            both accessible through word loads/stores on the data bus. Drives
//            a registered machine-timer-pending level.
// Ports    : clk             - system clock, rising edge
//            rst             - asynchronous active-low reset
//            addr[31:0]      - byte address (ALU result)
//            wdata[31:0]     - store data
//            rd_en / wr_en   - load / store strobes
//            rdata[31:0]     - combinational load data (0 unless hit && rd_en)
//            hit             - address falls in the 32-byte register window
//            timer_interrupt - registered en && (mtime >= mtimecmp)
// Register map (offset = addr[4:2]):
//            0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi,
//            4 ctrl (bit0 = en), 5..7 read 0 / writes ignored
// Revision : 1.0 - initial release
// ============================================================================
module mtimer #(
  parameter int          PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        timer_interrupt
);

  localparam logic [15:0] C_PCNT_MAX = 16'(PRESCALE - 1);

  localparam logic [2:0] C_OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] C_OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] C_OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] C_OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] C_OFF_CTRL     = 3'd4;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        irq_q, irq_d;

  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_tick;
  logic        w_unused_addr;

  // Byte-lane bits are not decoded: word access only.
  assign w_unused_addr = ^addr[1:0];

  assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off  = addr[4:2];
  assign w_wr   = hit && wr_en;
  assign w_tick = en_q && (pcnt_q == C_PCNT_MAX);

  always_comb begin
    en_d = en_q;
    if (w_wr && (w_off == C_OFF_CTRL)) begin
      en_d = wdata[0];
    end

    // Prescaler is held at 0 while disabled, and clears on the same edge a
    // write drops en, so a later enable always restarts from 0.
    pcnt_d = pcnt_q + 16'd1;
    if (!en_q || !en_d || w_tick) begin
      pcnt_d = 16'd0;
    end

    // A store to either mtime half overrides the increment; the tick is lost
    // and the other half keeps its pre-edge value.
    mtime_d = mtime_q + {63'd0, w_tick};
    if (w_wr && (w_off == C_OFF_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], wdata};
    end else if (w_wr && (w_off == C_OFF_MTIME_HI)) begin
      mtime_d = {wdata, mtime_q[31:0]};
    end

    mtimecmp_d = mtimecmp_q;
    if (w_wr && (w_off == C_OFF_CMP_LO)) begin
      mtimecmp_d = {mtimecmp_q[63:32], wdata};
    end else if (w_wr && (w_off == C_OFF_CMP_HI)) begin
      mtimecmp_d = {wdata, mtimecmp_q[31:0]};
    end

    // Compare uses pre-edge register values.
    irq_d = en_q && (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      pcnt_q     <= 16'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

  assign timer_interrupt = irq_q;

  always_comb begin
    rdata = 32'h0;
    if (hit && rd_en) begin
      case (w_off)
        C_OFF_MTIME_LO: rdata = mtime_q[31:0];
        C_OFF_MTIME_HI: rdata = mtime_q[63:32];
        C_OFF_CMP_LO:   rdata = mtimecmp_q[31:0];
        C_OFF_CMP_HI:   rdata = mtimecmp_q[63:32];
        C_OFF_CTRL:     rdata = {31'd0, en_q};
        default:        rdata = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtimer
// Purpose  : Self-checking bench for mtimer. Two instances (PRESCALE 1 and 4)
//            share one bus; a behavioural model tracks both and is compared
//            against the outputs every falling edge, alongside hand-computed
//            directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtimer;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        hit1, hit4, irq1, irq4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mtimer #(.PRESCALE(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_en(rd_en),
    .wr_en(wr_en), .rdata(rdata1), .hit(hit1), .timer_interrupt(irq1)
  );

  mtimer #(.PRESCALE(4), .BASE_ADDR(BASE)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_en(rd_en),
    .wr_en(wr_en), .rdata(rdata4), .hit(hit4), .timer_interrupt(irq4)
  );

  // ---------------- behavioural model (index 0: P=1, index 1: P=4) ----------
  int          m_p [2] = '{1, 4};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_en   [2];
  int          m_pcnt [2];
  logic        m_irq  [2];

  function automatic logic m_hit();
    return addr[31:5] == BASE[31:5];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] = 64'd0;
        m_cmp[k]  = '1;
        m_en[k]   = 1'b0;
        m_pcnt[k] = 0;
        m_irq[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic        wr, tick, nen;
        logic [63:0] nt, nc;
        int          off, np;
        wr   = wr_en && m_hit();
        off  = int'(addr[4:2]);
        tick = m_en[k] && (m_pcnt[k] == m_p[k] - 1);
        m_irq[k] = m_en[k] && (m_time[k] >= m_cmp[k]);
        nt = tick ? m_time[k] + 64'd1 : m_time[k];
        nc = m_cmp[k];
        nen = m_en[k];
        if (wr) begin
          case (off)
            0: nt = {m_time[k][63:32], wdata};
            1: nt = {wdata, m_time[k][31:0]};
            2: nc = {m_cmp[k][63:32], wdata};
            3: nc = {wdata, m_cmp[k][31:0]};
            4: nen = wdata[0];
            default: ;
          endcase
        end
        np = m_en[k] ? (m_pcnt[k] + 1) % m_p[k] : 0;
        if (!nen) np = 0;
        m_time[k] = nt;
        m_cmp[k]  = nc;
        m_en[k]   = nen;
        m_pcnt[k] = np;
      end
    end
  end

  function automatic logic [31:0] m_rdata(int k);
    if (!(m_hit() && rd_en)) return 32'h0;
    case (int'(addr[4:2]))
      0: return m_time[k][31:0];
      1: return m_time[k][63:32];
      2: return m_cmp[k][31:0];
      3: return m_cmp[k][63:32];
      4: return {31'd0, m_en[k]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model.
  always @(negedge clk) begin
    chk("cyc_rdata_p1", rdata1, m_rdata(0));
    chk("cyc_rdata_p4", rdata4, m_rdata(1));
    chk("cyc_hit_p1", {31'd0, hit1}, {31'd0, m_hit()});
    chk("cyc_hit_p4", {31'd0, hit4}, {31'd0, m_hit()});
    chk("cyc_irq_p1", {31'd0, irq1}, {31'd0, m_irq[0]});
    chk("cyc_irq_p4", {31'd0, irq4}, {31'd0, m_irq[1]});
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    addr  = BASE + {27'd0, off, 2'b00};
    wdata = d;
    wr_en = 1'b1;
    rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  // Presents a read for one cycle; checks selected instances at the falling edge.
  task automatic rd(input logic [2:0] off, input logic [31:0] e1, input logic [31:0] e4,
                    input bit c1, input bit c4, input string nm);
    addr  = BASE + {27'd0, off, 2'b00};
    rd_en = 1'b1;
    @(negedge clk);
    if (c1) chk({nm, "_p1"}, rdata1, e1);
    if (c4) chk({nm, "_p4"}, rdata4, e4);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state
    chk("rst_irq_p1", {31'd0, irq1}, 32'd0);
    chk("rst_irq_p4", {31'd0, irq4}, 32'd0);
    rd(3'd0, 32'h0, 32'h0, 1, 1, "rst_mtime_lo");
    rd(3'd1, 32'h0, 32'h0, 1, 1, "rst_mtime_hi");
    rd(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, "rst_cmp_lo");
    rd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, "rst_cmp_hi");
    rd(3'd4, 32'h0, 32'h0, 1, 1, "rst_ctrl");
    rd(3'd5, 32'h0, 32'h0, 1, 1, "rst_off14");
    idle(100);
    rd(3'd0, 32'h0, 32'h0, 1, 1, "idle_mtime_lo");

    // Non-hit store: nothing changes, rdata and hit are 0
    addr  = BASE + 32'h20;
    wdata = 32'hDEAD_BEEF;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    chk("nohit_hit", {31'd0, hit1}, 32'd0);
    chk("nohit_rdata", rdata1, 32'h0);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rd(3'd0, 32'h0, 32'h0, 1, 1, "nohit_mtime_lo");
    wr(3'd5, 32'h1234_5678);
    rd(3'd5, 32'h0, 32'h0, 1, 1, "off14_write_ignored");

    // PRESCALE=4: 40 edges after enable -> mtime 10, then hold when disabled
    wr(3'd4, 32'h1);
    idle(40);
    rd(3'd0, 32'h0, 32'd10, 0, 1, "pre4_mtime");
    chk("model_pre4_mtime", m_time[1][31:0], 32'd10);
    wr(3'd4, 32'h0);
    idle(20);
    rd(3'd0, 32'h0, 32'd10, 0, 1, "pre4_hold");
    rd(3'd4, 32'h0, 32'h0, 1, 1, "ctrl_off");

    // Carry from low to high word, then full 64-bit wrap (PRESCALE=1)
    wr(3'd4, 32'h1);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'h0);
    idle(1);
    rd(3'd0, 32'h0, 32'h0, 1, 0, "carry_lo");
    rd(3'd1, 32'h1, 32'h0, 1, 0, "carry_hi");
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    idle(1);
    rd(3'd0, 32'h0, 32'h0, 1, 0, "wrap_lo");
    rd(3'd1, 32'h0, 32'h0, 1, 0, "wrap_hi");

    // Interrupt rises one edge after mtime reaches mtimecmp
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'd5);
    wr(3'd4, 32'h1);
    idle(5);
    addr  = BASE;
    rd_en = 1'b1;
    @(negedge clk);
    chk("irq_mtime5", rdata1, 32'd5);
    chk("irq_low_at5", {31'd0, irq1}, 32'd0);
    step();
    rd_en = 1'b0;
    @(negedge clk);
    chk("irq_rise", {31'd0, irq1}, 32'd1);
    step();
    // Raising mtimecmp clears it two edges after the store
    wr(3'd2, 32'd100);
    @(negedge clk);
    chk("irq_still_high", {31'd0, irq1}, 32'd1);
    step();
    @(negedge clk);
    chk("irq_fall", {31'd0, irq1}, 32'd0);
    step();

    // Store to mtime_lo in a tick cycle wins over the increment
    wr(3'd0, 32'h1234);
    rd(3'd0, 32'h1234, 32'h1234, 1, 1, "tick_write");
    @(negedge clk);
    chk("irq_after_tickwr_p1", {31'd0, irq1}, 32'd1);
    chk("irq_after_tickwr_p4", {31'd0, irq4}, 32'd1);
    step();

    // Asynchronous reset mid-cycle
    addr  = BASE;
    rd_en = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("arst_irq_p1", {31'd0, irq1}, 32'd0);
    chk("arst_irq_p4", {31'd0, irq4}, 32'd0);
    chk("arst_mtime_p1", rdata1, 32'h0);
    step();
    rst   = 1'b1;
    rd_en = 1'b0;
    rd(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, "arst_cmp_lo");
    rd(3'd4, 32'h0, 32'h0, 1, 1, "arst_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer that generates the `timer_interrupt` level consumed by the CSR unit's trap input. It holds a 64-bit `mtime` counter, advanced by a programmable prescaler, and a 64-bit `mtimecmp` compare register. Both are reachable through word loads and stores on the data-memory address/data bus. It sits beside `data_mem` on the ALU result address and `rdata2` store data. Its read data enters the load path through the same load mux.

## Interface
- `PRESCALE`, default 1: clock cycles per `mtime` increment; legal range 1..65535.
- `BASE_ADDR`, default 32'h0000_2000: 32-byte-aligned base of the register window.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (`rdata2`).
- `rd_en` in 1: load strobe.
- `wr_en` in 1: store strobe.
- `rdata` out 32: load data, combinational.
- `hit` out 1: combinational; `addr[31:5] == BASE_ADDR[31:5]`.
- `timer_interrupt` out 1: registered machine-timer-pending level.

## Operation
- Register map (offset = `addr[4:2]`; `addr[1:0]` ignored; word access only):
  - 0x00: `mtime[31:0]`.
  - 0x04: `mtime[63:32]`.
  - 0x08: `mtimecmp[31:0]`.
  - 0x0C: `mtimecmp[63:32]`.
  - 0x10: `ctrl`, where bit0 = `en` and bits 31:1 read 0.
  - 0x14–0x1C: read 0; writes ignored.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `en` = 0.
  - Prescaler count = 0.
  - `timer_interrupt` = 0.
- Reads:
  - `rdata` = selected register when `hit && rd_en`; otherwise 32'h0.
  - Reads never change state.
- Writes: take effect at the clock edge when `hit && wr_en`; the write replaces the full word.
- Prescaler (16-bit count `pcnt`):
  - While `en` = 0: `pcnt` is held at 0 and `mtime` holds.
  - While `en` = 1: `pcnt` counts 0..PRESCALE-1 and wraps. A tick is generated in the cycle where `pcnt == PRESCALE-1`.
  - On a tick, `mtime` ← `mtime + 1` as a full 64-bit add; the carry from the low word propagates into the high word.
  - `mtime` wraps from all-ones to 0, and the wrap is silent.
- Write-versus-tick priority:
  - A write to offset 0x00 or 0x04 in a tick cycle wins. The addressed half takes `wdata`, the other half holds, and that tick is lost.
  - `pcnt` keeps counting regardless of the write.
- Writing `ctrl.en` 1→0 clears `pcnt` on the same edge. Writing 0→1 starts counting from `pcnt` = 0.
- Interrupt:
  - On each edge, `timer_interrupt` ← `en && (mtime >= mtimecmp)`. The comparison is unsigned 64-bit and uses the register values from before the edge.
  - The output is a level with no internal latch or ack. Software clears it by raising `mtimecmp` or clearing `en`.
- Simultaneous `rd_en` and `wr_en`: the read returns the pre-write value; the write commits at the edge.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 edge.
- The first `mtime` increment occurs PRESCALE edges after the edge that sets `en`.
- Interrupt latency: `timer_interrupt` rises exactly 1 edge after the registers first satisfy `mtime >= mtimecmp` with `en` = 1. It falls 1 edge after the condition fails.
- Writing `mtimecmp` to a value ≤ `mtime` asserts `timer_interrupt` 2 edges after the write: 1 edge to commit, 1 edge to register.
- Reset mid-count: all state returns to reset values immediately and asynchronously. `timer_interrupt` drops without waiting for a clock.
- Non-hit accesses: no state change, and `rdata` = 0.

## Test plan
- Reset, then read every offset → `mtime` = 0, `mtimecmp` = FFFF_FFFF/FFFF_FFFF, `ctrl` = 0, offset 0x14 = 0, `timer_interrupt` = 0. `mtime` is still 0 after 100 cycles.
- PRESCALE=4, write `ctrl` = 1, run 40 cycles → `mtime` = 10. Write `ctrl` = 0, then after 20 cycles `mtime` still = 10.
- Write `mtime_lo` = FFFF_FFFF and `mtime_hi` = 0 with PRESCALE=1 and `en` = 1 → one tick later `mtime` = 0000_0001_0000_0000. Repeat from all-ones → `mtime` wraps to 0.
- `mtimecmp` = 5, `mtime` = 0, PRESCALE=1, `en` = 1 → `timer_interrupt` rises on the edge after `mtime` reads 5. Write `mtimecmp_lo` = 100 → it falls 2 edges later.
- Write `mtime_lo` = 0x1234 in a tick cycle → `mtime` = 0x1234, not 0x1235. Then assert async `rst` mid-count → `timer_interrupt` = 0 and `mtime` = 0 immediately.
- Access `addr` = BASE_ADDR+0x20 with `wr_en` = 1 → no register changes, `hit` = 0, `rdata` = 0.
